// File: rtl/pwm_pkg.sv
// pwm_pkg: shared types and constants for the PWM duty-ramp sequencer.
//   ramp_state_e : sequencer state encoding, also exported on state_o
//   PWM_W        : default width of period/duty values
//   PWM_HOLD_W   : default width of the dwell (hold) counter
//   DIR_UP/DOWN  : direction select for the saturating step unit
package pwm_pkg;

   localparam int PWM_W      = 32;
   localparam int PWM_HOLD_W = 16;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      RAMP_UP   = 3'd1,
      HOLD_HI   = 3'd2,
      RAMP_DOWN = 3'd3,
      HOLD_LO   = 3'd4
   } ramp_state_e;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/sat_step.sv
// sat_step: combinational saturating duty step with period clamp.
//   duty_i      : current duty
//   step_i      : step size (0 behaves as 1)
//   period_i    : upper bound for duty
//   dir_i       : DIR_UP adds the step, DIR_DOWN subtracts it
//   duty_o      : next duty, always within [0, period_i]
//   hit_limit_o : the step reached period_i (up) or 0 (down)
module sat_step
   import pwm_pkg::*;
#(
   parameter int W = PWM_W
) (
   input  logic [W-1:0] duty_i,
   input  logic [W-1:0] step_i,
   input  logic [W-1:0] period_i,
   input  logic         dir_i,
   output logic [W-1:0] duty_o,
   output logic         hit_limit_o
);

   logic [W-1:0] clamped;
   logic [W-1:0] step_eff;
   logic [W:0]   sum;

   always_comb begin
      // A period that shrank below the current duty pulls duty down first,
      // so the step is applied to a value that is already in range.
      clamped  = (duty_i > period_i) ? period_i : duty_i;
      step_eff = (step_i == '0) ? W'(1) : step_i;
      // One extra bit so duty+step can never wrap around.
      sum      = {1'b0, clamped} + {1'b0, step_eff};

      duty_o      = clamped;
      hit_limit_o = 1'b0;
      if (dir_i == DIR_UP) begin
         if (sum >= {1'b0, period_i}) begin
            duty_o      = period_i;
            hit_limit_o = 1'b1;
         end else begin
            duty_o = sum[W-1:0];
         end
      end else begin
         if (clamped <= step_eff) begin
            duty_o      = '0;
            hit_limit_o = 1'b1;
         end else begin
            duty_o = clamped - step_eff;
         end
      end
   end

endmodule

// File: rtl/pwm_duty_ramp.sv
// pwm_duty_ramp: "breathing" duty sequencer feeding the PWM core.
// Ramps duty up to the period, dwells, ramps down to 0, dwells, repeats.
// Duty only moves on the PWM core's end-of-period pulse so each PWM
// period sees one constant duty.
//   clk          : system clock
//   rst_n        : synchronous active-low reset
//   enable       : run the sequencer; low returns to IDLE with duty 0
//   period_i     : current PWM period, upper bound for duty
//   step_i       : duty change per PWM period (0 behaves as 1)
//   hold_i       : extra PWM periods to dwell at each extreme
//   co_i         : end-of-period pulse from the PWM core
//   duty_o       : registered duty to the PWM core
//   state_o      : current ramp_state_e encoding
//   cycle_done_o : one-cycle pulse when a full breath completes
module pwm_duty_ramp
   import pwm_pkg::*;
#(
   parameter int W  = PWM_W,
   parameter int HW = PWM_HOLD_W
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          enable,
   input  logic [W-1:0]  period_i,
   input  logic [W-1:0]  step_i,
   input  logic [HW-1:0] hold_i,
   input  logic          co_i,
   output logic [W-1:0]  duty_o,
   output logic [2:0]    state_o,
   output logic          cycle_done_o
);

   ramp_state_e   state_q, state_d;
   logic [W-1:0]  duty_q,  duty_d;
   logic [HW-1:0] cnt_q,   cnt_d;
   logic          done_q,  done_d;

   logic [W-1:0]  step_duty;
   logic          step_hit;
   logic          step_dir;
   logic [W-1:0]  duty_clamped;

   // HOLD_LO exits by stepping up, HOLD_HI exits by stepping down, so the
   // single step unit follows the direction of the move that can occur next.
   assign step_dir     = (state_q == RAMP_UP || state_q == HOLD_LO) ? DIR_UP : DIR_DOWN;
   assign duty_clamped = (duty_q > period_i) ? period_i : duty_q;

   sat_step #(
      .W (W)
   ) u_sat_step (
      .duty_i      (duty_q),
      .step_i      (step_i),
      .period_i    (period_i),
      .dir_i       (step_dir),
      .duty_o      (step_duty),
      .hit_limit_o (step_hit)
   );

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         duty_q  <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         duty_q  <= duty_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      duty_d  = duty_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;

      if (!enable) begin
         // enable outranks a coincident co_i
         state_d = IDLE;
         duty_d  = '0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = RAMP_UP;
               duty_d  = '0;
            end
            RAMP_UP: begin
               if (co_i) begin
                  duty_d = step_duty;
                  if (step_hit) begin
                     state_d = HOLD_HI;
                     cnt_d   = hold_i;
                  end
               end
            end
            HOLD_HI: begin
               if (co_i) begin
                  if (cnt_q != '0) begin
                     cnt_d  = cnt_q - HW'(1);
                     duty_d = duty_clamped;
                  end else begin
                     // First decrement rides on the exit edge, giving
                     // hold_i+1 periods at the top.
                     state_d = RAMP_DOWN;
                     duty_d  = step_duty;
                  end
               end
            end
            RAMP_DOWN: begin
               if (co_i) begin
                  duty_d = step_duty;
                  if (step_hit) begin
                     state_d = HOLD_LO;
                     cnt_d   = hold_i;
                  end
               end
            end
            HOLD_LO: begin
               if (co_i) begin
                  if (cnt_q != '0) begin
                     cnt_d  = cnt_q - HW'(1);
                     duty_d = duty_clamped;
                  end else begin
                     state_d = RAMP_UP;
                     duty_d  = step_duty;
                     done_d  = 1'b1;
                  end
               end
            end
            default: begin
               state_d = IDLE;
               duty_d  = '0;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Outputs
   always_comb begin
      duty_o       = duty_q;
      state_o      = state_q;
      cycle_done_o = done_q;
   end

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Testbench for pwm_duty_ramp: directed stimulus with a scoreboard queue.
// The driver pushes the expected outputs for each checked cycle; a monitor
// pops and compares on the falling edge after the DUT has updated.
module tb_pwm_duty_ramp;
   import pwm_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic [31:0] period_i;
   logic [31:0] step_i;
   logic [15:0] hold_i;
   logic        co_i;
   logic [31:0] duty_o;
   logic [2:0]  state_o;
   logic        cycle_done_o;

   always #5 clk = ~clk;

   pwm_duty_ramp #(
      .W  (32),
      .HW (16)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .enable       (enable),
      .period_i     (period_i),
      .step_i       (step_i),
      .hold_i       (hold_i),
      .co_i         (co_i),
      .duty_o       (duty_o),
      .state_o      (state_o),
      .cycle_done_o (cycle_done_o)
   );

   typedef struct {
      logic [31:0] duty;
      logic [2:0]  state;
      logic        done;
      string       tag;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int   checks = 0;
   int   errors = 0;
   logic req    = 1'b0;
   logic req_q  = 1'b0;

   // A check requested with the inputs of one cycle is due once that
   // cycle's edge has updated the DUT.
   always @(posedge clk) req_q <= req;

   always @(negedge clk) begin
      if (req_q) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty got no expectation required one");
         end else begin
            e = q.pop_front();
            checks++;
            if (duty_o !== e.duty) begin
               errors++;
               $display("FAIL %s duty got %0d required %0d", e.tag, duty_o, e.duty);
            end
            checks++;
            if (state_o !== e.state) begin
               errors++;
               $display("FAIL %s state got %0d required %0d", e.tag, state_o, e.state);
            end
            checks++;
            if (cycle_done_o !== e.done) begin
               errors++;
               $display("FAIL %s cycle_done got %0d required %0d", e.tag, cycle_done_o, e.done);
            end
            $display("txn %s duty=%0d state=%0d done=%0d", e.tag, duty_o, state_o, cycle_done_o);
         end
      end
   end

   // Drive one cycle of inputs; optionally queue the outputs expected after it.
   task automatic drive(input logic co, input logic en, input logic rn, input logic chk,
                        input logic [31:0] ed, input logic [2:0] es, input logic edn,
                        input string tag);
      exp_t x;
      @(posedge clk);
      #1;
      co_i   = co;
      enable = en;
      rst_n  = rn;
      req    = chk;
      if (chk) begin
         x.duty  = ed;
         x.state = es;
         x.done  = edn;
         x.tag   = tag;
         q.push_back(x);
      end
   endtask

   // gap idle cycles, then one checked co pulse (enable=1, out of reset).
   task automatic co_after(input int gap, input logic [31:0] ed, input logic [2:0] es,
                           input logic edn, input string tag);
      repeat (gap) drive(1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 3'd0, 1'b0, "");
      drive(1'b1, 1'b1, 1'b1, 1'b1, ed, es, edn, tag);
   endtask

   // Change configuration in a cycle without co so a pending pulse still
   // sees the old values.
   task automatic cfg(input logic [31:0] p, input logic [31:0] s, input logic [15:0] h);
      @(posedge clk);
      #1;
      co_i     = 1'b0;
      req      = 1'b0;
      period_i = p;
      step_i   = s;
      hold_i   = h;
   endtask

   initial begin
      rst_n    = 1'b0;
      enable   = 1'b0;
      co_i     = 1'b0;
      period_i = 32'd10;
      step_i   = 32'd3;
      hold_i   = 16'd0;
      repeat (3) @(posedge clk);

      drive(1'b0, 1'b0, 1'b0, 1'b1, 32'd0, IDLE, 1'b0, "reset");
      drive(1'b0, 1'b1, 1'b1, 1'b1, 32'd0, RAMP_UP, 1'b0, "idle_exit");

      // Up ramp, hold, down ramp, breath complete (co every 12 clk)
      co_after(11, 32'd3,  RAMP_UP,   1'b0, "up1");
      co_after(11, 32'd6,  RAMP_UP,   1'b0, "up2");
      co_after(11, 32'd9,  RAMP_UP,   1'b0, "up3");
      co_after(11, 32'd10, HOLD_HI,   1'b0, "up_sat");
      co_after(11, 32'd7,  RAMP_DOWN, 1'b0, "hold_exit");
      co_after(11, 32'd4,  RAMP_DOWN, 1'b0, "down2");
      co_after(11, 32'd1,  RAMP_DOWN, 1'b0, "down3");
      co_after(11, 32'd0,  HOLD_LO,   1'b0, "down_floor");
      co_after(11, 32'd3,  RAMP_UP,   1'b1, "breath_done");
      drive(1'b0, 1'b1, 1'b1, 1'b1, 32'd3, RAMP_UP, 1'b0, "done_one_clk");

      // enable dropped together with co while duty=6
      co_after(3, 32'd6, RAMP_UP, 1'b0, "up_again");
      drive(1'b1, 1'b0, 1'b1, 1'b1, 32'd0, IDLE, 1'b0, "enable_priority");

      // Hold count: period=4 step=4 hold=2
      cfg(32'd4, 32'd4, 16'd2);
      drive(1'b0, 1'b1, 1'b1, 1'b1, 32'd0, RAMP_UP, 1'b0, "idle_exit2");
      co_after(2, 32'd4, HOLD_HI,   1'b0, "hh1");
      co_after(2, 32'd4, HOLD_HI,   1'b0, "hh2");
      co_after(2, 32'd4, HOLD_HI,   1'b0, "hh3");
      co_after(2, 32'd0, RAMP_DOWN, 1'b0, "hh_exit");
      co_after(2, 32'd0, HOLD_LO,   1'b0, "hl1");
      co_after(2, 32'd0, HOLD_LO,   1'b0, "hl2");
      co_after(2, 32'd0, HOLD_LO,   1'b0, "hl3");
      co_after(2, 32'd4, RAMP_UP,   1'b1, "hl_exit");

      // Reset in the middle of RAMP_DOWN
      cfg(32'd10, 32'd3, 16'd0);
      co_after(2, 32'd7,  RAMP_UP,   1'b0, "r_up");
      co_after(2, 32'd10, HOLD_HI,   1'b0, "r_sat");
      co_after(2, 32'd7,  RAMP_DOWN, 1'b0, "r_down");
      drive(1'b0, 1'b1, 1'b0, 1'b1, 32'd0, IDLE, 1'b0, "reset_mid");
      drive(1'b0, 1'b1, 1'b1, 1'b1, 32'd0, RAMP_UP, 1'b0, "after_reset");

      // Period shrinks under the current duty
      co_after(2, 32'd3, RAMP_UP, 1'b0, "s_up1");
      co_after(2, 32'd6, RAMP_UP, 1'b0, "s_up2");
      co_after(2, 32'd9, RAMP_UP, 1'b0, "s_up3");
      cfg(32'd5, 32'd3, 16'd0);
      co_after(2, 32'd5, HOLD_HI, 1'b0, "shrink");

      // step_i=0 behaves as 1
      cfg(32'd3, 32'd0, 16'd0);
      drive(1'b0, 1'b0, 1'b1, 1'b1, 32'd0, IDLE, 1'b0, "disable");
      drive(1'b0, 1'b1, 1'b1, 1'b1, 32'd0, RAMP_UP, 1'b0, "idle_exit3");
      co_after(2, 32'd1, RAMP_UP, 1'b0, "z_up1");
      co_after(2, 32'd2, RAMP_UP, 1'b0, "z_up2");
      co_after(2, 32'd3, HOLD_HI, 1'b0, "z_up3");

      // No co for 100 clk: nothing moves
      for (int i = 0; i < 100; i++)
         drive(1'b0, 1'b1, 1'b1, 1'b1, 32'd3, HOLD_HI, 1'b0, "no_co");

      // period_i=0: duty pinned at 0 while states keep cycling
      cfg(32'd0, 32'd3, 16'd0);
      co_after(2, 32'd0, RAMP_DOWN, 1'b0, "p0_hh_exit");
      co_after(2, 32'd0, HOLD_LO,   1'b0, "p0_down");
      co_after(2, 32'd0, RAMP_UP,   1'b1, "p0_breath");
      co_after(2, 32'd0, HOLD_HI,   1'b0, "p0_up");

      repeat (3) drive(1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 3'd0, 1'b0, "");
      repeat (2) @(posedge clk);

      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got %0d pending required 0", q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
